// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-ported word memory, data-first with anti-starvation for fetch.
// Latency: grant in the cycle after the request is sampled in IDLE, valid one cycle after grant; one access per 3 cycles.
// Backpressure: none; requests are sampled only in IDLE and the requester holds req until it sees its grant.
module mem_arbiter #(
    parameter int DEPTH      = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] I_ACC = 2'd1;
    localparam logic [1:0] D_ACC = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
    localparam logic [1:0]  STARVE_LIM = 2'(STARVE_MAX);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [1:0]  starve_cnt;
    logic [1:0]  starve_nxt;

    logic [29:0] lat_idx;
    logic        lat_we;
    logic [31:0] lat_wdata;
    logic        lat_is_d;

    logic        in_acc;
    logic        in_range;

    // Byte offset within a word is don't-care for a word-addressed memory.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    assign in_acc   = (state == I_ACC) || (state == D_ACC);
    assign in_range = ({2'b00, lat_idx} < DEPTH_W);

    // Arbitration: data wins ties until fetch has lost STARVE_MAX times in a row.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            IDLE: begin
                if (i_req && d_req && (starve_cnt != STARVE_LIM)) begin
                    state_nxt  = D_ACC;
                    starve_nxt = starve_cnt + 2'd1;
                end else if (i_req) begin
                    state_nxt  = I_ACC;
                    starve_nxt = 2'd0;
                end else if (d_req) begin
                    state_nxt  = D_ACC;
                    starve_nxt = 2'd0;
                end else begin
                    state_nxt  = IDLE;
                    starve_nxt = 2'd0;
                end
            end
            I_ACC:   state_nxt = DONE;
            D_ACC:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            starve_cnt <= 2'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Winner's request is captured on the grant edge so the requester is free to move on.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lat_idx   <= 30'd0;
            lat_we    <= 1'b0;
            lat_wdata <= 32'd0;
            lat_is_d  <= 1'b0;
        end else if (state == IDLE) begin
            if (state_nxt == I_ACC) begin
                lat_idx   <= i_addr[31:2];
                lat_we    <= 1'b0;
                lat_wdata <= 32'd0;
                lat_is_d  <= 1'b0;
            end else if (state_nxt == D_ACC) begin
                lat_idx   <= d_addr[31:2];
                lat_we    <= d_we;
                lat_wdata <= d_wdata;
                lat_is_d  <= 1'b1;
            end
        end
    end

    // Completion results hold until the same port finishes another access.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            i_rdata <= 32'd0;
            i_err   <= 1'b0;
            d_rdata <= 32'd0;
            d_err   <= 1'b0;
        end else if (state == I_ACC) begin
            i_rdata <= in_range ? mem_rd : 32'd0;
            i_err   <= !in_range;
        end else if (state == D_ACC) begin
            d_rdata <= (in_range && !lat_we) ? mem_rd : 32'd0;
            d_err   <= !in_range;
        end
    end

    assign i_gnt    = (state == I_ACC);
    assign d_gnt    = (state == D_ACC);
    assign i_valid  = (state == DONE) && !lat_is_d;
    assign d_valid  = (state == DONE) &&  lat_is_d;

    assign mem_we   = (state == D_ACC) && lat_we && in_range;
    assign mem_addr = in_acc ? {2'b00, lat_idx} : 32'd0;
    assign mem_wd   = in_acc ? lat_wdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 64-word behavioural memory on the mem_* side.
module tb_mem_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    logic        mem_init;

    int n_cmp;
    int n_bad;

    mem_arbiter #(.DEPTH(64), .STARVE_MAX(3)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_valid (i_valid),
        .i_rdata (i_rdata),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_valid (d_valid),
        .d_rdata (d_rdata),
        .d_err   (d_err),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign mem_rd = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'hBAD0_BAD0;

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'(k) * 32'h0101_0101;
            mem[0] <= 32'hA5A5_A5A5;
            mem[5] <= 32'h2002_000A;
        end else if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wd;
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Rst_n = 1'b0; mem_init = 1'b1;
        i_req = 1'b1; i_addr = 32'h14;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        tick;
        mem_init = 1'b0;
        tick;
        n_cmp++;
        if ({i_gnt, d_gnt, i_valid, d_valid, i_err, d_err, mem_we} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000000", {i_gnt, d_gnt, i_valid, d_valid, i_err, d_err, mem_we});
        end
        n_cmp++;
        if ({i_rdata, d_rdata, mem_addr, mem_wd} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h want all 0", i_rdata, d_rdata, mem_addr, mem_wd);
        end
        Rst_n = 1'b1;
    endtask

    // i_req was already high at reset release; the first edge must grant it.
    task automatic test_fetch;
        tick;
        n_cmp++;
        if ({i_gnt, d_gnt, mem_we} !== 3'b100) begin
            n_bad++; $display("FAIL fetch_gnt: got %b want 100", {i_gnt, d_gnt, mem_we});
        end
        n_cmp++;
        if (mem_addr !== 32'd5) begin
            n_bad++; $display("FAIL fetch_mem_addr: got %0d want 5", mem_addr);
        end
        i_req = 1'b0; i_addr = 32'hFFFF_FFFF;
        tick;
        n_cmp++;
        if ({i_valid, i_gnt, i_err} !== 3'b100) begin
            n_bad++; $display("FAIL fetch_valid: got %b want 100", {i_valid, i_gnt, i_err});
        end
        n_cmp++;
        if (i_rdata !== 32'h2002_000A) begin
            n_bad++; $display("FAIL fetch_rdata: got %h want 2002000a", i_rdata);
        end
        tick;
        n_cmp++;
        if (i_valid !== 1'b0) begin
            n_bad++; $display("FAIL fetch_valid_pulse: got %b want 0", i_valid);
        end
    endtask

    task automatic test_write_read;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        tick;
        n_cmp++;
        if ({d_gnt, i_gnt, mem_we} !== 3'b101) begin
            n_bad++; $display("FAIL wr_gnt: got %b want 101", {d_gnt, i_gnt, mem_we});
        end
        n_cmp++;
        if ({mem_addr, mem_wd} !== {32'd8, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL wr_bus: got %h/%h want 8/deadbeef", mem_addr, mem_wd);
        end
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        tick;
        n_cmp++;
        if ({d_valid, d_err, mem_we} !== 3'b100 || d_rdata !== 32'd0) begin
            n_bad++; $display("FAIL wr_done: got %b rdata %h want 100 rdata 0", {d_valid, d_err, mem_we}, d_rdata);
        end
        n_cmp++;
        if (mem[8] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL wr_mem8: got %h want deadbeef", mem[8]);
        end
        tick;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h23;
        tick;
        n_cmp++;
        if ({d_gnt, mem_we, mem_addr} !== {2'b10, 32'd8}) begin
            n_bad++; $display("FAIL rd_gnt: got %b addr %0d want 10 addr 8", {d_gnt, mem_we}, mem_addr);
        end
        d_req = 1'b0;
        tick;
        n_cmp++;
        if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rd_data: got v=%b %h want v=1 deadbeef", d_valid, d_rdata);
        end
        tick;
    endtask

    task automatic test_out_of_range;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        tick;
        n_cmp++;
        if ({d_gnt, mem_we} !== 2'b10) begin
            n_bad++; $display("FAIL oor_we: got %b want 10", {d_gnt, mem_we});
        end
        d_req = 1'b0; d_we = 1'b0;
        tick;
        n_cmp++;
        if ({d_valid, d_err} !== 2'b11 || d_rdata !== 32'd0) begin
            n_bad++; $display("FAIL oor_done: got %b rdata %h want 11 rdata 0", {d_valid, d_err}, d_rdata);
        end
        n_cmp++;
        if (mem[0] !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL oor_mem0: got %h want a5a5a5a5", mem[0]);
        end
        tick;
        i_req = 1'b1; i_addr = 32'h200;
        tick;
        i_req = 1'b0;
        tick;
        n_cmp++;
        if ({i_valid, i_err} !== 2'b11 || i_rdata !== 32'd0) begin
            n_bad++; $display("FAIL oor_fetch: got %b rdata %h want 11 rdata 0", {i_valid, i_err}, i_rdata);
        end
        n_cmp++;
        if (d_err !== 1'b1) begin
            n_bad++; $display("FAIL oor_d_err_hold: got %b want 1", d_err);
        end
        tick;
    endtask

    task automatic test_starvation;
        string       exp_seq;
        logic [7:0]  who [8];
        int          gcyc [8];
        int          ng;
        int          both;
        exp_seq = "DDDIDDDI";
        ng = 0; both = 0;
        for (int k = 0; k < 8; k++) begin who[k] = "?"; gcyc[k] = 0; end
        i_addr = 32'h14; d_addr = 32'h20; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
            tick;
            if (i_gnt && d_gnt) both++;
            if (i_gnt || d_gnt) begin
                who[ng]  = i_gnt ? "I" : "D";
                gcyc[ng] = cyc;
                ng++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if (ng != 8) begin
            n_bad++; $display("FAIL starve_grants: got %0d grants want 8 within 40 cycles", ng);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (who[k] !== exp_seq[k]) begin
                n_bad++; $display("FAIL starve_order[%0d]: got %s want %s", k, who[k], exp_seq[k]);
            end
        end
        n_cmp++;
        if (both != 0) begin
            n_bad++; $display("FAIL starve_dual_gnt: got %0d cycles want 0", both);
        end
        n_cmp++;
        if (gcyc[1] - gcyc[0] != 3) begin
            n_bad++; $display("FAIL b2b_gap: got %0d cycles want 3", gcyc[1] - gcyc[0]);
        end
        tick;
        tick;
        n_cmp++;
        if (i_rdata !== 32'h2002_000A || d_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL starve_rdata: got %h/%h want 2002000a/deadbeef", i_rdata, d_rdata);
        end
    endtask

    task automatic test_reset_mid_write;
        int vcount;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1111_1111;
        tick;
        n_cmp++;
        if (mem_we !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_we: got %b want 1", mem_we);
        end
        Rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we, d_gnt} !== 2'b00) begin
            n_bad++; $display("FAIL rst_we_drop: got %b want 00", {mem_we, d_gnt});
        end
        tick;
        n_cmp++;
        if (mem[8] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rst_mem8: got %h want deadbeef", mem[8]);
        end
        n_cmp++;
        if (d_valid !== 1'b0 || d_rdata !== 32'd0) begin
            n_bad++; $display("FAIL rst_outputs: got v=%b %h want v=0 0", d_valid, d_rdata);
        end
        Rst_n = 1'b1;
        tick;
        vcount = 0;
        for (int k = 0; k < 3; k++) begin
            if (d_valid) vcount++;
            tick;
        end
        n_cmp++;
        if (vcount != 0) begin
            n_bad++; $display("FAIL rst_no_valid: got %0d pulses want 0", vcount);
        end
        d_req = 1'b1; d_addr = 32'h20;
        tick;
        n_cmp++;
        if ({d_gnt, d_valid} !== 2'b10) begin
            n_bad++; $display("FAIL rst_next_gnt: got %b want 10", {d_gnt, d_valid});
        end
        d_req = 1'b0;
        tick;
        n_cmp++;
        if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rst_next_rd: got v=%b %h want v=1 deadbeef", d_valid, d_rdata);
        end
        tick;
    endtask

    task automatic test_late_requests;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
        tick;
        i_req = 1'b1; i_addr = 32'h14; d_req = 1'b0;
        #1;
        n_cmp++;
        if ({d_gnt, i_gnt} !== 2'b10) begin
            n_bad++; $display("FAIL late_acc: got %b want 10", {d_gnt, i_gnt});
        end
        tick;
        n_cmp++;
        if ({d_valid, i_gnt, d_gnt} !== 3'b100 || d_rdata !== 32'h2002_000A) begin
            n_bad++; $display("FAIL late_done: got %b %h want 100 2002000a", {d_valid, i_gnt, d_gnt}, d_rdata);
        end
        tick;
        n_cmp++;
        if (i_gnt !== 1'b0) begin
            n_bad++; $display("FAIL late_idle: got %b want 0", i_gnt);
        end
        tick;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            n_bad++; $display("FAIL late_gnt: got %b want 10", {i_gnt, d_gnt});
        end
        i_req = 1'b0;
        tick;
        n_cmp++;
        if (i_valid !== 1'b1 || i_rdata !== 32'h2002_000A || i_err !== 1'b0) begin
            n_bad++; $display("FAIL late_fetch: got v=%b %h e=%b want v=1 2002000a e=0", i_valid, i_rdata, i_err);
        end
        tick;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_fetch;
        test_write_read;
        test_out_of_range;
        test_starvation;
        test_reset_mid_write;
        test_late_requests;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
